// File: rtl/fill_sequencer_pkg.sv
// Shared constants and state encoding for the pill-bottle fill sequencer.
package fill_sequencer_pkg;

    localparam int unsigned CNT_W_DEF       = 14;
    localparam int unsigned TIMEOUT_CYC_DEF = 50_000_000;
    localparam int unsigned STATE_W         = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_BOT = 3'd1,
        ST_FILL     = 3'd2,
        ST_ADVANCE  = 3'd3,
        ST_PAUSED   = 3'd4,
        ST_DONE     = 3'd5,
        ST_FAULT    = 3'd6
    } state_t;

endpackage

// File: rtl/jam_watchdog.sv
// Jam watchdog: counts run cycles since the last kick; expires after TIMEOUT_CYC of them.
module jam_watchdog
    import fill_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic run,
    input  logic kick,
    output logic expired
);

    localparam int unsigned        WD_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0]    LIMIT = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] r_cnt;
    logic            w_at_limit;

    assign w_at_limit = (r_cnt == LIMIT);

    // Holds (rather than clears) while not running, so a pause does not reset the jam timer.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_cnt <= '0;
        end else if (kick) begin
            r_cnt <= '0;
        end else if (run && !w_at_limit) begin
            r_cnt <= r_cnt + WD_W'(1);
        end
    end

    assign expired = run && w_at_limit;

endmodule

// File: rtl/fill_sequencer.sv
// Batch fill sequencer: dispenses cfg_pills into each of cfg_bottles bottles,
// with pause support and a jam watchdog that forces a fault on a stalled dispenser.
module fill_sequencer
    import fill_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               start,
    input  logic               ack,
    input  logic               pause,
    input  logic [CNT_W-1:0]   cfg_bottles,
    input  logic [CNT_W-1:0]   cfg_pills,
    input  logic               bottle_ready,
    input  logic               pill_tick,
    output logic               drop_en,
    output logic               bottle_adv,
    output logic [CNT_W-1:0]   now_pills,
    output logic [CNT_W-1:0]   bottles_done,
    output logic               busy,
    output logic               finish,
    output logic               stop,
    output logic [STATE_W-1:0] state
);

    state_t           r_state;
    state_t           w_next;
    state_t           r_ret;
    logic [CNT_W-1:0] r_cfg_bottles;
    logic [CNT_W-1:0] r_cfg_pills;
    logic [CNT_W-1:0] r_now_pills;
    logic [CNT_W-1:0] r_bottles_done;
    logic [CNT_W-1:0] w_pills_inc;
    logic [CNT_W-1:0] w_bottles_inc;
    logic             w_idle_like;
    logic             w_tick_fill;
    logic             w_target;
    logic             w_wd_run;
    logic             w_wd_kick;
    logic             w_wd_expired;

    assign w_idle_like   = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_tick_fill   = (r_state == ST_FILL) && pill_tick;
    assign w_pills_inc   = CNT_W'(r_now_pills + CNT_W'(1));
    assign w_bottles_inc = CNT_W'(r_bottles_done + CNT_W'(1));
    assign w_target      = w_tick_fill && (w_pills_inc == r_cfg_pills);

    // Reload on every counted pill and on fresh FILL entry, but not on return from PAUSED.
    assign w_wd_run  = (r_state == ST_FILL);
    assign w_wd_kick = w_tick_fill || ((r_state == ST_WAIT_BOT) && (w_next == ST_FILL));

    jam_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_jam_watchdog (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .run     (w_wd_run),
        .kick    (w_wd_kick),
        .expired (w_wd_expired)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
            r_ret   <= ST_IDLE;
        end else begin
            r_state <= w_next;
            if ((w_next == ST_PAUSED) && (r_state != ST_PAUSED)) begin
                r_ret <= r_state;
            end
        end
    end

    // In FILL: target tick beats jam expiry, which beats pause.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_next = ((cfg_bottles == '0) || (cfg_pills == '0)) ? ST_FAULT : ST_WAIT_BOT;
                end
            end
            ST_WAIT_BOT: begin
                if (pause) begin
                    w_next = ST_PAUSED;
                end else if (bottle_ready) begin
                    w_next = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_target) begin
                    w_next = ST_ADVANCE;
                end else if (w_wd_expired && !pill_tick) begin
                    w_next = ST_FAULT;
                end else if (pause) begin
                    w_next = ST_PAUSED;
                end
            end
            ST_ADVANCE: begin
                w_next = (w_bottles_inc == r_cfg_bottles) ? ST_DONE : ST_WAIT_BOT;
            end
            ST_PAUSED: begin
                if (!pause) begin
                    w_next = r_ret;
                end
            end
            ST_FAULT: begin
                if (ack) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Config latch and pill/bottle counters; bounded by the latched config so they never wrap.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_cfg_bottles  <= '0;
            r_cfg_pills    <= '0;
            r_now_pills    <= '0;
            r_bottles_done <= '0;
        end else if (w_idle_like && start) begin
            r_cfg_bottles  <= cfg_bottles;
            r_cfg_pills    <= cfg_pills;
            r_now_pills    <= '0;
            r_bottles_done <= '0;
        end else if (w_tick_fill) begin
            r_now_pills <= w_pills_inc;
        end else if (r_state == ST_ADVANCE) begin
            r_now_pills    <= '0;
            r_bottles_done <= w_bottles_inc;
        end
    end

    assign drop_en      = (r_state == ST_FILL);
    assign bottle_adv   = (r_state == ST_ADVANCE);
    assign busy         = (r_state == ST_WAIT_BOT) || (r_state == ST_FILL) ||
                          (r_state == ST_ADVANCE)  || (r_state == ST_PAUSED);
    assign finish       = (r_state == ST_DONE);
    assign stop         = (r_state == ST_FAULT);
    assign state        = r_state;
    assign now_pills    = r_now_pills;
    assign bottles_done = r_bottles_done;

endmodule

// File: tb/tb_fill_sequencer.sv
// Scoreboard bench for fill_sequencer: directed batches push expected events,
// a negedge monitor pops and compares on each bottle_adv / finish / stop event.
module tb_fill_sequencer;
    import fill_sequencer_pkg::*;

    localparam int unsigned CW = 14;
    localparam int unsigned TO = 16;

    localparam logic [1:0] EV_ADV   = 2'd1;
    localparam logic [1:0] EV_DONE  = 2'd2;
    localparam logic [1:0] EV_FAULT = 2'd3;

    typedef struct packed {
        logic [1:0]    kind;
        logic [CW-1:0] pills;
        logic [CW-1:0] bottles;
    } ev_t;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          start;
    logic          ack;
    logic          pause;
    logic [CW-1:0] cfg_bottles;
    logic [CW-1:0] cfg_pills;
    logic          bottle_ready;
    logic          pill_tick;
    logic          drop_en;
    logic          bottle_adv;
    logic [CW-1:0] now_pills;
    logic [CW-1:0] bottles_done;
    logic          busy;
    logic          finish;
    logic          stop;
    logic [2:0]    state;

    ev_t  exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_ev  = 0;
    logic saw_drop    = 1'b0;
    logic saw_paused  = 1'b0;
    logic prev_finish = 1'b0;
    logic prev_stop   = 1'b0;

    always #5 sys_clk = ~sys_clk;

    fill_sequencer #(
        .TIMEOUT_CYC (TO),
        .CNT_W       (CW)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .start        (start),
        .ack          (ack),
        .pause        (pause),
        .cfg_bottles  (cfg_bottles),
        .cfg_pills    (cfg_pills),
        .bottle_ready (bottle_ready),
        .pill_tick    (pill_tick),
        .drop_en      (drop_en),
        .bottle_adv   (bottle_adv),
        .now_pills    (now_pills),
        .bottles_done (bottles_done),
        .busy         (busy),
        .finish       (finish),
        .stop         (stop),
        .state        (state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [1:0] k, input int unsigned p, input int unsigned b);
        ev_t e;
        e.kind    = k;
        e.pills   = CW'(p);
        e.bottles = CW'(b);
        exp_q.push_back(e);
    endtask

    task automatic score(input logic [1:0] k);
        ev_t got;
        ev_t want;
        got.kind    = k;
        got.pills   = now_pills;
        got.bottles = bottles_done;
        n_cmp++;
        n_ev++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL event%0d unexpected: kind=%0d pills=%0d bottles=%0d",
                     n_ev, got.kind, got.pills, got.bottles);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                n_err++;
                $display("FAIL event%0d: got kind=%0d pills=%0d bottles=%0d want kind=%0d pills=%0d bottles=%0d",
                         n_ev, got.kind, got.pills, got.bottles, want.kind, want.pills, want.bottles);
            end
        end
    endtask

    // Monitor: sample away from the active edge and score each observable event.
    always @(negedge sys_clk) begin
        if (drop_en === 1'b1) saw_drop = 1'b1;
        if (state === 3'(ST_PAUSED)) saw_paused = 1'b1;
        if (bottle_adv === 1'b1) score(EV_ADV);
        if (finish === 1'b1 && prev_finish !== 1'b1) score(EV_DONE);
        if (stop === 1'b1 && prev_stop !== 1'b1) score(EV_FAULT);
        prev_finish = finish;
        prev_stop   = stop;
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic wait_state(input state_t st, input int budget, input string name);
        int n;
        n = 0;
        while (state !== 3'(st) && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(state), 32'(st));
    endtask

    task automatic drop_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            wait_state(ST_FILL, 20, "tick_wait_fill");
            pill_tick = 1'b1;
            tick();
            pill_tick = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;
        sys_rst      = 1'b1;
        start        = 1'b0;
        ack          = 1'b0;
        pause        = 1'b0;
        bottle_ready = 1'b0;
        pill_tick    = 1'b0;
        cfg_bottles  = '0;
        cfg_pills    = '0;
        tick();
        // Reset must win over a simultaneous start.
        cfg_bottles = CW'(2);
        cfg_pills   = CW'(3);
        start       = 1'b1;
        tick();
        start = 1'b0;
        check("rst_state", 32'(state), 32'(ST_IDLE));
        check("rst_drop_en", 32'(drop_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_finish", 32'(finish), 32'd0);
        check("rst_stop", 32'(stop), 32'd0);
        check("rst_now_pills", 32'(now_pills), 32'd0);
        check("rst_bottles_done", 32'(bottles_done), 32'd0);
        sys_rst = 1'b0;
        tick();

        // Nominal batch 2 bottles x 3 pills.
        bottle_ready = 1'b1;
        expect_ev(EV_ADV, 3, 0);
        expect_ev(EV_ADV, 3, 1);
        expect_ev(EV_DONE, 0, 2);
        pulse_start();
        check("nom_wait_bot", 32'(state), 32'(ST_WAIT_BOT));
        check("nom_busy", 32'(busy), 32'd1);
        wait_state(ST_FILL, 5, "nom_enter_fill");
        check("nom_drop_en", 32'(drop_en), 32'd1);
        drop_ticks(6);
        wait_state(ST_DONE, 10, "nom_done");
        check("nom_finish", 32'(finish), 32'd1);
        check("nom_bottles_done", 32'(bottles_done), 32'd2);
        check("nom_now_pills", 32'(now_pills), 32'd0);
        check("nom_busy_done", 32'(busy), 32'd0);

        // Zero config from DONE: immediate fault, counters cleared.
        saw_drop  = 1'b0;
        cfg_pills = '0;
        expect_ev(EV_FAULT, 0, 0);
        pulse_start();
        check("zero_state", 32'(state), 32'(ST_FAULT));
        check("zero_stop", 32'(stop), 32'd1);
        check("zero_drop_en", 32'(drop_en), 32'd0);
        cfg_pills = CW'(3);
        pulse_start();
        check("zero_start_ignored", 32'(state), 32'(ST_FAULT));
        pulse_ack();
        check("zero_ack_idle", 32'(state), 32'(ST_IDLE));
        check("zero_stop_clear", 32'(stop), 32'd0);
        check("zero_never_drop", 32'(saw_drop), 32'd0);

        // Pause after 1 of 3 pills, held for 40 cycles (longer than the jam limit).
        cfg_bottles = CW'(1);
        cfg_pills   = CW'(3);
        expect_ev(EV_ADV, 3, 0);
        expect_ev(EV_DONE, 0, 1);
        pulse_start();
        drop_ticks(1);
        pause = 1'b1;
        tick();
        check("pause_state", 32'(state), 32'(ST_PAUSED));
        bad = 0;
        repeat (40) begin
            tick();
            if (drop_en !== 1'b0 || stop !== 1'b0 || now_pills !== CW'(1) || state !== 3'(ST_PAUSED))
                bad++;
        end
        check("pause_hold_bad_cycles", 32'(bad), 32'd0);
        pause = 1'b0;
        tick();
        check("pause_resume_fill", 32'(state), 32'(ST_FILL));
        check("pause_resume_pills", 32'(now_pills), 32'd1);
        drop_ticks(2);
        wait_state(ST_DONE, 10, "pause_done");
        check("pause_bottles_done", 32'(bottles_done), 32'd1);

        // Jam: no pills for TO cycles in FILL.
        cfg_bottles = CW'(1);
        cfg_pills   = CW'(2);
        expect_ev(EV_FAULT, 0, 0);
        pulse_start();
        wait_state(ST_FILL, 5, "jam_enter_fill");
        n = 0;
        while (state !== 3'(ST_FAULT) && n < 40) begin
            tick();
            n++;
        end
        check("jam_cycles", 32'(n), 32'(TO));
        check("jam_stop", 32'(stop), 32'd1);
        check("jam_drop_en", 32'(drop_en), 32'd0);
        pulse_start();
        check("jam_start_ignored", 32'(state), 32'(ST_FAULT));
        pulse_ack();
        check("jam_ack_idle", 32'(state), 32'(ST_IDLE));

        // Reset mid-batch with now_pills=2; a same-cycle tick must not count.
        cfg_bottles = CW'(2);
        cfg_pills   = CW'(3);
        pulse_start();
        drop_ticks(2);
        check("mid_now_pills", 32'(now_pills), 32'd2);
        check("mid_state_fill", 32'(state), 32'(ST_FILL));
        sys_rst   = 1'b1;
        pill_tick = 1'b1;
        tick();
        sys_rst   = 1'b0;
        pill_tick = 1'b0;
        check("mid_rst_state", 32'(state), 32'(ST_IDLE));
        check("mid_rst_now_pills", 32'(now_pills), 32'd0);
        check("mid_rst_bottles", 32'(bottles_done), 32'd0);
        check("mid_rst_outs", 32'({drop_en, bottle_adv, busy, finish, stop}), 32'd0);

        // Final pill of last bottle arriving with pause: ADVANCE then DONE, never PAUSED.
        saw_paused  = 1'b0;
        cfg_bottles = CW'(1);
        cfg_pills   = CW'(2);
        expect_ev(EV_ADV, 2, 0);
        expect_ev(EV_DONE, 0, 1);
        pulse_start();
        drop_ticks(1);
        wait_state(ST_FILL, 5, "sim_fill");
        pause     = 1'b1;
        pill_tick = 1'b1;
        tick();
        pill_tick = 1'b0;
        check("sim_advance", 32'(state), 32'(ST_ADVANCE));
        check("sim_bottle_adv", 32'(bottle_adv), 32'd1);
        tick();
        check("sim_done", 32'(state), 32'(ST_DONE));
        pause = 1'b0;
        tick();
        check("sim_never_paused", 32'(saw_paused), 32'd0);

        repeat (3) tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fill_sequencer.md
FILL_SEQUENCER -- requirements
Module: fill_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYC, default 50_000_000: jam-watchdog limit in sys_clk cycles (1 s at 50 MHz).
REQ-002 Parameter CNT_W, default 14: width of all count ports.
REQ-003 sys_clk  in  1  single clock; all logic on rising edge.
REQ-004 sys_rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  1-cycle pulse; begins a batch.
REQ-006 ack  in  1  1-cycle pulse; clears FAULT.
REQ-007 pause  in  1  level; suspends dispensing while high.
REQ-008 cfg_bottles  in  CNT_W  bottles per batch.
REQ-009 cfg_pills  in  CNT_W  pills per bottle.
REQ-010 bottle_ready  in  1  level; empty bottle is under the chute.
REQ-011 pill_tick  in  1  1-cycle pulse; one pill has dropped.
REQ-012 drop_en  out  1  dispenser gate.
REQ-013 bottle_adv  out  1  1-cycle conveyor-advance pulse.
REQ-014 now_pills  out  CNT_W  pills in current bottle.
REQ-015 bottles_done  out  CNT_W  bottles completed in this batch.
REQ-016 busy, finish, stop  out  1 each  running / batch complete / fault.
REQ-017 state  out  3  current state encoding, for display and debug.

Function
REQ-018 States: IDLE, WAIT_BOT, FILL, ADVANCE, PAUSED, DONE, FAULT.
REQ-019 IDLE or DONE, start=1:
- Latch cfg_bottles and cfg_pills.
- Clear now_pills and bottles_done.
- Go to WAIT_BOT, or to FAULT if either cfg value is 0.
REQ-020 start SHALL be ignored in WAIT_BOT, FILL, ADVANCE, PAUSED and FAULT.
REQ-021 WAIT_BOT: bottle_ready=1 goes to FILL on the next edge.
REQ-022 FILL: drop_en=1.
- Each pill_tick increments now_pills.
- A tick that makes now_pills equal the latched cfg_pills goes to ADVANCE.
REQ-023 pill_tick SHALL be ignored in every state except FILL.
REQ-024 ADVANCE lasts exactly one cycle:
- bottle_adv=1, bottles_done+1, now_pills cleared to 0.
- Next state is DONE if the new bottles_done equals the latched cfg_bottles, else WAIT_BOT.
REQ-025 pause=1 in WAIT_BOT or FILL goes to PAUSED and records the return state.
- When pause returns to 0, go back to the recorded state.
- drop_en=0 while PAUSED.
REQ-026 Same-cycle priority in FILL: a target-reaching tick (ADVANCE) beats watchdog expiry (FAULT), which beats pause (PAUSED).
- A non-target tick together with pause is counted, then the block pauses.
REQ-027 Watchdog counts FILL cycles since the last pill_tick or FILL entry.
- It reloads on every tick and holds while PAUSED.
- Reaching TIMEOUT_CYC goes to FAULT.
REQ-028 FAULT: stop=1, drop_en=0, counters hold. ack=1 goes to IDLE.
REQ-029 DONE: finish=1 and the counters hold until the next start or reset.
REQ-030 busy=1 in WAIT_BOT, FILL, ADVANCE and PAUSED; 0 otherwise.
REQ-031 All outputs SHALL be registered or decoded from the state register only, with no combinational path from input to output.
REQ-032 Counters SHALL NOT wrap: they are bounded by the latched cfg values, which are at most 2^CNT_W-1.

Reset
REQ-033 sys_rst=1 at any edge, including mid-batch, forces IDLE and sets:
- drop_en=0, bottle_adv=0, busy=0, finish=0, stop=0.
- now_pills=0, bottles_done=0, latched cfg=0, watchdog=0.
REQ-034 Reset SHALL override every other input in the same cycle.

Structure
REQ-035 A shared package SHALL hold:
- the state encoding constants;
- CNT_W;
- the TIMEOUT_CYC default.
REQ-036 The watchdog SHALL be a sub-module, jam_watchdog, with ports sys_clk, sys_rst, run, kick, expired.
REQ-037 The state machine and counters SHALL stay in fill_sequencer; no other sub-modules.

Verification (TIMEOUT_CYC=16)
REQ-038 Nominal batch: cfg 2/3, start, bottle_ready held, 6 ticks.
- Exactly 2 bottle_adv pulses.
- finish=1 with bottles_done=2 and now_pills=0.
REQ-039 Zero config: cfg_pills=0, then start.
- stop=1 next cycle, drop_en never asserted.
- ack returns the block to IDLE.
REQ-040 Pause mid-fill: pause high after 1 of 3 ticks, hold 40 cycles.
- drop_en=0, no FAULT, now_pills=1 throughout.
- After release, FILL resumes and completes normally.
REQ-041 Jam: in FILL with no ticks for 16 cycles.
- stop=1, drop_en=0.
- start ignored until ack.
REQ-042 Reset mid-batch: sys_rst pulsed during FILL with now_pills=2.
- All outputs at reset values next cycle, state=IDLE.
REQ-043 Simultaneous events: pause and the final tick of the last bottle in the same cycle.
- ADVANCE, then DONE.
- bottle_adv pulses once, and PAUSED is never entered.
